// File: rtl/keypad_prio_encoder.sv
// keypad_prio_encoder: registered, debounced priority encoder for keypad lines with one active-low load strobe per press.
// Optional macro KEY_REPEAT_EN adds auto-repeat strobes while a key stays held.
module keypad_prio_encoder #(
  parameter int N_KEYS        = 10,
  parameter int CODE_W        = 4,
  parameter int DEBOUNCE      = 4,
  parameter int REPEAT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [N_KEYS-1:0] d_in,
  output logic [CODE_W-1:0] d_out,
  output logic              loadn,
  output logic              key_held
);
`ifdef KEY_REPEAT_EN
  localparam int CMAX = DEBOUNCE > REPEAT_CYCLES ? DEBOUNCE : REPEAT_CYCLES;
`else
  localparam int CMAX = DEBOUNCE;
`endif
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_CYCLES - 1);
`endif
  typedef enum logic [2:0] {S_IDLE, S_DEB, S_STROBE, S_HOLD, S_REL} state_t;
  state_t            state, state_n;
  logic [N_KEYS-1:0] sync_r;
  logic [CW-1:0]     cnt, cnt_n;
  logic [CODE_W-1:0] cand, cand_n, cur_code;
  logic              any_key;
  always_comb begin
    cur_code = '0;
    for (int i = 0; i < N_KEYS; i++)
      if (sync_r[i]) cur_code = CODE_W'(i);
  end
  assign any_key = |sync_r;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    if (!enable) begin
      state_n = S_IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        S_IDLE:
          if (any_key) begin
            state_n = S_DEB;
            cand_n  = cur_code;
            cnt_n   = '0;
          end
        S_DEB:
          if (!any_key) begin
            state_n = S_IDLE;
            cnt_n   = '0;
          end else if (cur_code != cand) begin
            cand_n = cur_code;
            cnt_n  = '0;
          end else if (cnt == DB_LAST) begin
            state_n = S_STROBE;
            cnt_n   = '0;
          end else cnt_n = cnt + 1'b1;
        S_STROBE: begin
          state_n = S_HOLD;
          cnt_n   = '0;
        end
        S_HOLD:
          if (!any_key) begin
            state_n = S_REL;
            cnt_n   = '0;
          end
`ifdef KEY_REPEAT_EN
          // repeats reuse the strobe state so spacing is REPEAT_CYCLES+1
          else if (cnt == RP_LAST) begin
            state_n = S_STROBE;
            cnt_n   = '0;
          end else cnt_n = cnt + 1'b1;
`endif
        S_REL:
          if (any_key) begin
            state_n = S_HOLD;
            cnt_n   = '0;
          end else if (cnt == DB_LAST) begin
            state_n = S_IDLE;
            cnt_n   = '0;
          end else cnt_n = cnt + 1'b1;
        default: begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end
  // outputs are registered from the next state so they align with the state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r   <= '0;
      state    <= S_IDLE;
      cnt      <= '0;
      cand     <= '0;
      d_out    <= '0;
      loadn    <= 1'b1;
      key_held <= 1'b0;
    end else begin
      sync_r   <= d_in;
      state    <= state_n;
      cnt      <= cnt_n;
      cand     <= cand_n;
      loadn    <= state_n != S_STROBE;
      key_held <= state_n inside {S_STROBE, S_HOLD, S_REL};
      if (state_n == S_STROBE) d_out <= cand;
    end
  end
endmodule

// File: tb/tb_keypad_prio_encoder.sv
// tb_keypad_prio_encoder: directed checks of debounce, priority, strobe timing, release and optional repeat.
module tb_keypad_prio_encoder;
`ifdef KEY_REPEAT_EN
  localparam int REP = 1;
`else
  localparam int REP = 0;
`endif
  logic       clk = 0;
  logic       reset = 0;
  logic       enable = 0;
  logic [9:0] d_in = '0;
  logic [3:0] d_out;
  logic       loadn;
  logic       key_held;
  int         errors = 0;
  int         checks = 0;
  int         strobes = 0;
  int         bad_code = 0;
  keypad_prio_encoder dut (
    .clk(clk), .reset(reset), .enable(enable), .d_in(d_in),
    .d_out(d_out), .loadn(loadn), .key_held(key_held)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (loadn === 1'b0) begin
    strobes++;
    if (d_out == 4'd2) bad_code++;
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    #2 reset = 1; d_in = 10'h3FF;
    #1;
    chk("rst_dout", 32'(d_out), 0);
    chk("rst_loadn", 32'(loadn), 1);
    chk("rst_held", 32'(key_held), 0);
    step(3);
    reset = 0;
    step(10);
    chk("dis_loadn", 32'(loadn), 1);
    chk("dis_held", 32'(key_held), 0);
    chk("dis_dout", 32'(d_out), 0);
    chk("dis_strobes", 32'(strobes), 0);
    d_in = '0; enable = 1;
    step(3);
    strobes = 0;
    d_in = 10'h020;
    step(5);
    chk("press_early", 32'(loadn), 1);
    step(1);
    chk("press_loadn", 32'(loadn), 0);
    chk("press_dout", 32'(d_out), 5);
    chk("press_held", 32'(key_held), 1);
    step(1);
    chk("press_pulse1", 32'(loadn), 1);
    step(13);
    chk("press_count", 32'(strobes), 1);
    chk("press_held_on", 32'(key_held), 1);
    d_in = '0;
    step(4);
    chk("rel_still_held", 32'(key_held), 1);
    step(2);
    chk("rel_done", 32'(key_held), 0);
    chk("rel_count", 32'(strobes), 1);
    strobes = 0;
    for (int i = 0; i < 6; i++) begin
      d_in = i[0] ? 10'h000 : 10'h008;
      step(1);
    end
    chk("bounce_none", 32'(strobes), 0);
    d_in = 10'h208;
    step(8);
    chk("prio_count", 32'(strobes), 1);
    chk("prio_dout", 32'(d_out), 9);
    d_in = '0;
    step(8);
    chk("prio_rel", 32'(key_held), 0);
    strobes = 0; bad_code = 0;
    d_in = 10'h004;
    step(2);
    d_in = 10'h010;
    step(5);
    chk("chg_early", 32'(loadn), 1);
    step(1);
    chk("chg_loadn", 32'(loadn), 0);
    chk("chg_dout", 32'(d_out), 4);
    step(5);
    chk("chg_count", 32'(strobes), 1);
    chk("chg_no_code2", 32'(bad_code), 0);
    strobes = 0;
    d_in = '0;
    step(1);
    chk("glitch_held_a", 32'(key_held), 1);
    step(1);
    d_in = 10'h010;
    step(10);
    chk("glitch_held_b", 32'(key_held), 1);
    chk("glitch_none", 32'(strobes), 0);
    d_in = '0;
    step(8);
    chk("full_rel", 32'(key_held), 0);
    d_in = 10'h080;
    step(6);
    chk("k7_loadn", 32'(loadn), 0);
    chk("k7_dout", 32'(d_out), 7);
    step(2);
    chk("k7_count", 32'(strobes), 1);
    d_in = '0;
    step(8);
    strobes = 0;
    d_in = 10'h008;
    step(6);
    chk("rep_first", 32'(loadn), 0);
    chk("rep_dout", 32'(d_out), 3);
    step(16);
    chk("rep_gap", 32'(loadn), 1);
    step(1);
    chk("rep_second", 32'(loadn), REP ? 0 : 1);
    step(43);
    chk("rep_count", 32'(strobes), REP ? 4 : 1);
    chk("rep_dout_end", 32'(d_out), 3);
    enable = 0;
    step(2);
    chk("en_low_held", 32'(key_held), 0);
    chk("en_low_loadn", 32'(loadn), 1);
    chk("en_low_dout", 32'(d_out), 3);
    enable = 1; d_in = 10'h100;
    step(6);
    chk("re_en_dout", 32'(d_out), 8);
    step(2);
    #2 reset = 1;
    #1;
    chk("mid_rst_held", 32'(key_held), 0);
    chk("mid_rst_dout", 32'(d_out), 0);
    chk("mid_rst_loadn", 32'(loadn), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
